fullchip_seq: RTL and testbench

Hardware instruction sequencer that drives `fullchip` through a complete attention-score pass. Replaces the bench-driven stimulus. It accepts Q rows and per-core K rows over a valid/ready stream and issues the 17-bit `inst` word plus `acc`/`div`/`wr_norm`/`fifo_ext_rd`. Phase order: Q write, K write, K load, execute, ofifo→pmem, accumulate, normalize. It sits between the host/data source and `fullchip`, one instance per chip.

---
 rtl/fullchip_seq_if.sv | 32 +++
 rtl/fullchip_seq.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_fullchip_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fullchip_seq_if.sv
// Row stream from the host plus the command bundle the sequencer issues to fullchip.
interface fullchip_seq_if #(
  parameter int bw = 8,
  parameter int pr = 16
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [pr*bw-1:0]  data_in_core1;
  logic [pr*bw-1:0]  data_in_core2;
  logic [pr*bw-1:0]  mem_in_core1;
  logic [pr*bw-1:0]  mem_in_core2;
  logic [16:0]       inst;
  logic              acc;
  logic              div;
  logic              wr_norm;
  logic              fifo_ext_rd;
  logic              busy;
  logic              done;

  modport slave (
    input  start, in_valid, data_in_core1, data_in_core2,
    output in_ready, mem_in_core1, mem_in_core2, inst,
           acc, div, wr_norm, fifo_ext_rd, busy, done
  );

  modport master (
    output start, in_valid, data_in_core1, data_in_core2,
    input  in_ready, mem_in_core1, mem_in_core2, inst,
           acc, div, wr_norm, fifo_ext_rd, busy, done
  );
endinterface

// File: rtl/fullchip_seq.sv
// Instruction sequencer that walks fullchip through one attention-score pass:
// Q write, K write, K load, execute, ofifo->pmem, accumulate, normalize.
// Every output is registered; the next-cycle values are computed from the
// current state and phase counter, then captured together with the state.
module fullchip_seq #(
  parameter int bw          = 8,
  parameter int pr          = 16,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap         = 10
) (
  input logic           clk,
  input logic           reset,
  fullchip_seq_if.slave bus
);

  localparam int CW = 11;

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] TWO       = CW'(2);
  localparam logic [CW-1:0] T_LAST    = CW'(total_cycle - 1);
  localparam logic [CW-1:0] K_LAST    = CW'(col - 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(col);
  localparam logic [CW-1:0] GAP_LAST  = CW'((gap > 0) ? gap - 1 : 0);
  localparam logic [CW-1:0] ACC_LAST  = CW'(total_cycle);
  localparam logic [CW-1:0] NORM_DONE = CW'(2 * total_cycle + 2);

  localparam int B_OFIFO_RD = 16;
  localparam int B_EXECUTE  = 7;
  localparam int B_LOAD     = 6;
  localparam int B_QMEM_RD  = 5;
  localparam int B_QMEM_WR  = 4;
  localparam int B_KMEM_RD  = 3;
  localparam int B_KMEM_WR  = 2;
  localparam int B_PMEM_RD  = 1;
  localparam int B_PMEM_WR  = 0;

  typedef enum logic [3:0] {
    IDLE, QWR, KWR, LOAD, LOAD_END, GAP1, EXEC, GAP2, OFIFO, ACC, NORM
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [16:0]      inst_q, inst_d;
  logic [pr*bw-1:0] mem1_q, mem1_d;
  logic [pr*bw-1:0] mem2_q, mem2_d;
  logic             in_ready_q, in_ready_d;
  logic             acc_q, acc_d;
  logic             div_q, div_d;
  logic             wr_norm_q, wr_norm_d;
  logic             fifo_q, fifo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic [3:0]       add_m1;
  logic [3:0]       hold_add;
  logic [4:0]       norm_off;

  assign accept   = bus.in_valid & in_ready_q;
  assign add_m1   = cnt_q[3:0] - 4'd1;
  assign hold_add = (cnt_q == '0) ? 4'd0 : add_m1;
  assign norm_off = cnt_q[4:0] - 5'd2;

  assign bus.in_ready     = in_ready_q;
  assign bus.mem_in_core1 = mem1_q;
  assign bus.mem_in_core2 = mem2_q;
  assign bus.inst         = inst_q;
  assign bus.acc          = acc_q;
  assign bus.div          = div_q;
  assign bus.wr_norm      = wr_norm_q;
  assign bus.fifo_ext_rd  = fifo_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // Next state, phase counter and next-cycle output values for each phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inst_d     = '0;
    mem1_d     = '0;
    mem2_d     = '0;
    in_ready_d = 1'b0;
    acc_d      = 1'b0;
    div_d      = 1'b0;
    wr_norm_d  = 1'b0;
    fifo_d     = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d    = QWR;
          cnt_d      = '0;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end

      QWR: begin
        in_ready_d = 1'b1;
        if (accept) begin
          inst_d[B_QMEM_WR] = 1'b1;
          inst_d[15:12]     = cnt_q[3:0];
          mem1_d            = bus.data_in_core1;
          mem2_d            = bus.data_in_core2;
          if (cnt_q == T_LAST) begin
            state_d    = KWR;
            cnt_d      = '0;
            in_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          inst_d[15:12] = hold_add;
        end
      end

      KWR: begin
        in_ready_d = 1'b1;
        if (accept) begin
          inst_d[B_KMEM_WR] = 1'b1;
          inst_d[15:12]     = cnt_q[3:0];
          mem1_d            = bus.data_in_core1;
          mem2_d            = bus.data_in_core2;
          if (cnt_q == K_LAST) begin
            state_d    = LOAD;
            cnt_d      = '0;
            in_ready_d = 1'b0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          inst_d[15:12] = hold_add;
        end
      end

      LOAD: begin
        inst_d[B_LOAD] = 1'b1;
        if (cnt_q != '0) begin
          inst_d[B_KMEM_RD] = 1'b1;
          inst_d[15:12]     = add_m1;
        end
        if (cnt_q == LOAD_LAST) begin
          state_d = LOAD_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      LOAD_END: begin
        if (cnt_q == '0) begin
          inst_d[B_LOAD] = 1'b1;
          cnt_d          = ONE;
        end else begin
          state_d = (gap > 0) ? GAP1 : EXEC;
          cnt_d   = '0;
        end
      end

      GAP1: begin
        if (cnt_q == GAP_LAST) begin
          state_d = EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      EXEC: begin
        inst_d[B_EXECUTE] = 1'b1;
        inst_d[B_QMEM_RD] = 1'b1;
        inst_d[15:12]     = cnt_q[3:0];
        if (cnt_q == T_LAST) begin
          state_d = (gap > 0) ? GAP2 : OFIFO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      GAP2: begin
        if (cnt_q == GAP_LAST) begin
          state_d = OFIFO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      OFIFO: begin
        inst_d[B_OFIFO_RD] = 1'b1;
        inst_d[B_PMEM_WR]  = 1'b1;
        inst_d[11:8]       = cnt_q[3:0];
        if (cnt_q == T_LAST) begin
          state_d = ACC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      ACC: begin
        inst_d[B_PMEM_RD] = 1'b1;
        if (cnt_q != '0) begin
          acc_d        = 1'b1;
          inst_d[11:8] = add_m1;
        end
        if (cnt_q == ACC_LAST) begin
          state_d = NORM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      NORM: begin
        if (cnt_q == NORM_DONE) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          wr_norm_d = 1'b1;
          cnt_d     = cnt_q + ONE;
          if (cnt_q < TWO) begin
            inst_d[B_PMEM_RD] = 1'b1;
          end else if (!norm_off[0]) begin
            inst_d[B_PMEM_RD] = 1'b1;
            div_d             = 1'b1;
            fifo_d            = 1'b1;
            inst_d[11:8]      = norm_off[4:1];
          end else begin
            inst_d[B_PMEM_WR] = 1'b1;
            inst_d[11:8]      = norm_off[4:1];
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Capture state, counter and all outputs together; reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      inst_q     <= '0;
      mem1_q     <= '0;
      mem2_q     <= '0;
      in_ready_q <= 1'b0;
      acc_q      <= 1'b0;
      div_q      <= 1'b0;
      wr_norm_q  <= 1'b0;
      fifo_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      mem1_q     <= mem1_d;
      mem2_q     <= mem2_d;
      in_ready_q <= in_ready_d;
      acc_q      <= acc_d;
      div_q      <= div_d;
      wr_norm_q  <= wr_norm_d;
      fifo_q     <= fifo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_fullchip_seq.sv
// Directed bench for fullchip_seq: reset, full passes with and without
// backpressure, a stray start during EXEC and a reset in the middle of OFIFO.
module tb_fullchip_seq;

  localparam int BW  = 8;
  localparam int PR  = 16;
  localparam int COL = 8;
  localparam int T   = 8;
  localparam int GAP = 10;

  localparam logic [23:0] C_BUSY  = 24'h800000;
  localparam logic [23:0] C_DONE  = 24'h400000;
  localparam logic [23:0] C_RDY   = 24'h200000;
  localparam logic [23:0] C_ACC   = 24'h100000;
  localparam logic [23:0] C_DIV   = 24'h080000;
  localparam logic [23:0] C_WRN   = 24'h040000;
  localparam logic [23:0] C_FIFO  = 24'h020000;
  localparam logic [23:0] I_OFIFO = 24'h010000;
  localparam logic [23:0] I_EX    = 24'h000080;
  localparam logic [23:0] I_LD    = 24'h000040;
  localparam logic [23:0] I_QRD   = 24'h000020;
  localparam logic [23:0] I_QWR   = 24'h000010;
  localparam logic [23:0] I_KRD   = 24'h000008;
  localparam logic [23:0] I_KWR   = 24'h000004;
  localparam logic [23:0] I_PRD   = 24'h000002;
  localparam logic [23:0] I_PWR   = 24'h000001;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [23:0]  exp_ctl[$];
  logic [127:0] exp_m1[$];
  logic [127:0] exp_m2[$];
  bit           exp_mchk[$];

  fullchip_seq_if #(.bw(BW), .pr(PR)) bus();

  fullchip_seq #(
    .bw(BW), .pr(PR), .col(COL), .total_cycle(T), .gap(GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [23:0] qka(input int a);
    return 24'(a) << 12;
  endfunction

  function automatic logic [23:0] pma(input int a);
    return 24'(a) << 8;
  endfunction

  function automatic logic [127:0] qrow(input int r);
    return {16{8'(r + 1)}};
  endfunction

  function automatic logic [127:0] k1row(input int c);
    return {16{8'(8'h10 + c)}};
  endfunction

  function automatic logic [127:0] k2row(input int c);
    return {16{8'(8'h40 + c)}};
  endfunction

  function automatic logic [23:0] observed();
    return {bus.busy, bus.done, bus.in_ready, bus.acc, bus.div,
            bus.wr_norm, bus.fifo_ext_rd, bus.inst};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed_v,
                             input logic [127:0] expected_v);
    checks++;
    if (observed_v !== expected_v) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed_v, expected_v);
    end
  endtask

  task automatic pushExp(input logic [23:0] c, input logic [127:0] m1,
                         input logic [127:0] m2, input bit mchk);
    exp_ctl.push_back(c);
    exp_m1.push_back(m1);
    exp_m2.push_back(m2);
    exp_mchk.push_back(mchk);
  endtask

  // Hand-built per-cycle command trace starting the cycle after the first accept.
  task automatic buildExpected(input int stall_row, input int stall_len);
    exp_ctl.delete();
    exp_m1.delete();
    exp_m2.delete();
    exp_mchk.delete();
    for (int r = 0; r < T; r++) begin
      pushExp(C_BUSY | ((r < T - 1) ? C_RDY : 24'h0) | I_QWR | qka(r), qrow(r), qrow(r), 1'b1);
      if (r == stall_row - 1)
        for (int s = 0; s < stall_len; s++) pushExp(C_BUSY | C_RDY | qka(r), '0, '0, 1'b0);
    end
    pushExp(C_BUSY | C_RDY, '0, '0, 1'b0);
    for (int c = 0; c < COL; c++)
      pushExp(C_BUSY | ((c < COL - 1) ? C_RDY : 24'h0) | I_KWR | qka(c), k1row(c), k2row(c), 1'b1);
    pushExp(C_BUSY | I_LD, '0, '0, 1'b0);
    for (int c = 1; c <= COL; c++) pushExp(C_BUSY | I_LD | I_KRD | qka(c - 1), '0, '0, 1'b0);
    pushExp(C_BUSY | I_LD, '0, '0, 1'b0);
    pushExp(C_BUSY, '0, '0, 1'b0);
    for (int g = 0; g < GAP; g++) pushExp(C_BUSY, '0, '0, 1'b0);
    for (int t = 0; t < T; t++) pushExp(C_BUSY | I_EX | I_QRD | qka(t), '0, '0, 1'b0);
    for (int g = 0; g < GAP; g++) pushExp(C_BUSY, '0, '0, 1'b0);
    for (int t = 0; t < T; t++) pushExp(C_BUSY | I_OFIFO | I_PWR | pma(t), '0, '0, 1'b0);
    pushExp(C_BUSY | I_PRD, '0, '0, 1'b0);
    for (int t = 1; t <= T; t++) pushExp(C_BUSY | I_PRD | C_ACC | pma(t - 1), '0, '0, 1'b0);
    pushExp(C_BUSY | C_WRN | I_PRD, '0, '0, 1'b0);
    pushExp(C_BUSY | C_WRN | I_PRD, '0, '0, 1'b0);
    for (int r = 0; r < T; r++) begin
      pushExp(C_BUSY | C_WRN | I_PRD | C_DIV | C_FIFO | pma(r), '0, '0, 1'b0);
      pushExp(C_BUSY | C_WRN | I_PWR | pma(r), '0, '0, 1'b0);
    end
    pushExp(C_DONE, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) pushExp(24'h0, '0, '0, 1'b0);
  endtask

  // One pass: start, feed Q then K rows, compare every cycle against the trace.
  task automatic applyStimulus(input int stall_row, input int stall_len,
                               input int start_idx, input int reset_idx);
    int sent, stall_left, n_wrn, n_div, n_done, done_at;
    buildExpected(stall_row, stall_len);
    sent = 0; stall_left = stall_len; n_wrn = 0; n_div = 0; n_done = 0; done_at = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("start_busy", 128'(bus.busy), 128'(1));
    checkOutput("start_ready", 128'(bus.in_ready), 128'(1));
    for (int idx = 0; idx < exp_ctl.size(); idx++) begin
      if (sent < T + COL) begin
        bus.in_valid = !(sent == stall_row && stall_left > 0);
        if (!bus.in_valid) stall_left--;
        bus.data_in_core1 = (sent < T) ? qrow(sent) : k1row(sent - T);
        bus.data_in_core2 = (sent < T) ? qrow(sent) : k2row(sent - T);
        if (bus.in_valid && bus.in_ready === 1'b1) sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.start = (idx == start_idx);
      @(negedge clk);
      checkOutput($sformatf("ctl@%0d", idx), 128'(observed()), 128'(exp_ctl[idx]));
      if (exp_mchk[idx]) begin
        checkOutput($sformatf("mem1@%0d", idx), bus.mem_in_core1, exp_m1[idx]);
        checkOutput($sformatf("mem2@%0d", idx), bus.mem_in_core2, exp_m2[idx]);
      end
      if (bus.wr_norm === 1'b1) n_wrn++;
      if (bus.div === 1'b1) n_div++;
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = idx;
      end
      if (idx == reset_idx) begin
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput("rst_ctl", 128'(observed()), 128'(0));
        checkOutput("rst_mem1", bus.mem_in_core1, '0);
        checkOutput("rst_mem2", bus.mem_in_core2, '0);
        reset = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    if (reset_idx < 0) begin
      checkOutput("done_at", 128'(done_at), 128'(91 + stall_len));
      checkOutput("done_count", 128'(n_done), 128'(1));
      checkOutput("wr_norm_cycles", 128'(n_wrn), 128'(2 * T + 2));
      checkOutput("div_pulses", 128'(n_div), 128'(T));
    end
  endtask

  // Test sequence.
  initial begin
    reset = 1'b0;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    bus.data_in_core1 = '0;
    bus.data_in_core2 = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset_inst%0d", i), 128'(bus.inst), '0);
      checkOutput($sformatf("reset_busy%0d", i), 128'(bus.busy), '0);
      checkOutput($sformatf("reset_ready%0d", i), 128'(bus.in_ready), '0);
      checkOutput($sformatf("reset_done%0d", i), 128'(bus.done), '0);
    end
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] full pass, no stalls");
    applyStimulus(-1, 0, -1, -1);
    $display("[TB] backpressure after Q row 4");
    applyStimulus(5, 3, -1, -1);
    $display("[TB] start pulsed during EXEC");
    applyStimulus(-1, 0, 40, -1);
    $display("[TB] reset in OFIFO cycle 3");
    applyStimulus(-1, 0, -1, 59);
    $display("[TB] replay after reset");
    applyStimulus(-1, 0, -1, -1);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
